// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential add-shift multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SHIFT,
      DONE
   } state_t;

   localparam int         WIDTH     = 8;
   localparam logic [2:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the add-shift multiplier: sequences eight ADD/SHIFT pairs
// and produces the datapath strobes. Step strobes and status are registered;
// the IDLE load/start strobes are qualified by the registered idle flag.
module mult_ctrl_fsm
   import mult_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic load_b,
   input  logic start,
   output logic ld_b,
   output logic start_clr,
   output logic do_add,
   output logic do_shift,
   output logic add_sub,
   output logic busy,
   output logic done
);

   state_t     state_q;
   logic [2:0] cnt_q;
   logic       idle_q;
   logic       do_add_q;
   logic       do_shift_q;
   logic       add_sub_q;
   logic       busy_q;
   logic       done_q;

   // Load_B wins over Start; both only act while idle.
   assign ld_b      = idle_q & load_b;
   assign start_clr = idle_q & ~load_b & start;

   assign do_add   = do_add_q;
   assign do_shift = do_shift_q;
   assign add_sub  = add_sub_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // State, step counter and registered outputs advance together so every output matches the state it is in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         idle_q     <= 1'b1;
         do_add_q   <= 1'b0;
         do_shift_q <= 1'b0;
         add_sub_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!load_b && start) begin
                  state_q   <= ADD;
                  cnt_q     <= 3'd0;
                  idle_q    <= 1'b0;
                  do_add_q  <= 1'b1;
                  add_sub_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            ADD: begin
               state_q    <= SHIFT;
               do_add_q   <= 1'b0;
               do_shift_q <= 1'b1;
               add_sub_q  <= 1'b0;
            end
            SHIFT: begin
               do_shift_q <= 1'b0;
               if (cnt_q == LAST_STEP) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q  <= ADD;
                  cnt_q    <= cnt_q + 3'd1;
                  do_add_q <= 1'b1;
                  // The multiplier MSB carries weight -2^7, so its step subtracts.
                  add_sub_q <= ((cnt_q + 3'd1) == LAST_STEP);
               end
            end
            DONE: begin
               // Start held high must not re-trigger; wait for it to drop.
               if (!start) begin
                  state_q <= IDLE;
                  idle_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/mult_add_shift_seq.sv
// Sequential two's-complement add-shift multiplier. Holds the X:A:B shift
// register and the latched multiplicand M, drives the external 9-bit
// adder/subtractor and captures its sum into {X,A}.
module mult_add_shift_seq #(
   parameter int WIDTH = mult_pkg::WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Sw,
   input  logic             Load_B,
   input  logic             Start,
   output logic [WIDTH:0]   add_a,
   output logic [WIDTH:0]   add_b,
   output logic             add_sub,
   input  logic [WIDTH:0]   add_s,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   logic             x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;

   logic ld_b;
   logic start_clr;
   logic do_add;
   logic do_shift;

   mult_ctrl_fsm u_ctrl (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .load_b    (Load_B),
      .start     (Start),
      .ld_b      (ld_b),
      .start_clr (start_clr),
      .do_add    (do_add),
      .do_shift  (do_shift),
      .add_sub   (add_sub),
      .busy      (Busy),
      .done      (Done)
   );

   // Sign-extended operands so the 9-bit sum carries the true sign into X.
   assign add_a = {a_q[WIDTH-1], a_q};
   assign add_b = {m_q[WIDTH-1], m_q};

   assign Aval = a_q;
   assign Bval = b_q;
   assign X    = x_q;

   // Next-state of the datapath registers selected by the controller strobes.
   always_comb begin
      x_d = x_q;
      a_d = a_q;
      b_d = b_q;
      m_d = m_q;
      if (ld_b) begin
         b_d = Sw;
         a_d = '0;
         x_d = 1'b0;
      end else if (start_clr) begin
         m_d = Sw;
         a_d = '0;
         x_d = 1'b0;
      end else if (do_add) begin
         if (b_q[0]) begin
            {x_d, a_d} = add_s;
         end
      end else if (do_shift) begin
         // Arithmetic right shift of X:A:B; X keeps the sign.
         a_d = {x_q, a_q[WIDTH-1:1]};
         b_d = {a_q[0], b_q[WIDTH-1:1]};
      end
   end

   // Datapath registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         m_q <= '0;
      end else begin
         x_q <= x_d;
         a_q <= a_d;
         b_q <= b_d;
         m_q <= m_d;
      end
   end

endmodule
